// File: rtl/des_crack_regs_pkg.sv
// Register map, bit positions and response codes for the DES cracker control slave.
package des_crack_regs_pkg;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_STATUS   = 6'h04;
  localparam logic [5:0] ADDR_PT_LO    = 6'h08;
  localparam logic [5:0] ADDR_PT_HI    = 6'h0C;
  localparam logic [5:0] ADDR_CT_LO    = 6'h10;
  localparam logic [5:0] ADDR_CT_HI    = 6'h14;
  localparam logic [5:0] ADDR_KS_LO    = 6'h18;
  localparam logic [5:0] ADDR_KS_HI    = 6'h1C;
  localparam logic [5:0] ADDR_KE_LO    = 6'h20;
  localparam logic [5:0] ADDR_KE_HI    = 6'h24;
  localparam logic [5:0] ADDR_FKEY_LO  = 6'h28;
  localparam logic [5:0] ADDR_FKEY_HI  = 6'h2C;
  localparam logic [5:0] ADDR_IRQ_STAT = 6'h30;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_IRQ_EN   = 8;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_FOUND    = 1;
  localparam int STAT_REJ      = 2;
  localparam int STAT_CORE_LSB = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axil_resp_t;

  // Byte-lane merge: lanes with a clear strobe keep their old contents.
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/des_crack_axil_ctrl_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the control slave.
interface des_crack_axil_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid, arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid, rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/des_found_arbiter.sv
// Lowest-index priority pick among cores reporting a found key.
module des_found_arbiter #(
  parameter int N_CORES   = 4,
  parameter int KEY_WIDTH = 56
) (
  input  logic [N_CORES-1:0]           found,
  input  logic [N_CORES*KEY_WIDTH-1:0] keys,
  output logic                         any,
  output logic [3:0]                   idx,
  output logic [KEY_WIDTH-1:0]         key
);
  // Scan high to low so the lowest asserting core is the last (winning) assignment.
  always_comb begin
    any = |found;
    idx = '0;
    key = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (found[i]) begin
        idx = 4'(i);
        key = keys[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end
endmodule

// File: rtl/des_crack_axil_ctrl.sv
// AXI4-Lite control/status slave for the DES cracker core array.
module des_crack_axil_ctrl
  import des_crack_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int N_CORES            = 4,
  parameter int KEY_WIDTH          = 56
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  des_crack_axil_ctrl_if.slave         s_axi,
  output logic [63:0]                  o_plaintext,
  output logic [63:0]                  o_ciphertext,
  output logic [KEY_WIDTH-1:0]         o_key_start,
  output logic [KEY_WIDTH-1:0]         o_key_end,
  output logic                         o_start,
  output logic                         o_abort,
  input  logic [N_CORES-1:0]           i_core_busy,
  input  logic [N_CORES-1:0]           i_core_found,
  input  logic [N_CORES*KEY_WIDTH-1:0] i_core_key,
  output logic                         o_irq
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  logic                          aw_full, w_full;
  logic [AW-3:0]                 aw_word;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [3:0]                    w_strb;
  logic [7:0][31:0]              dregs;   // PT_LO..KE_HI in address order
  logic                          irq_en, found, start_rej, irq_found;
  logic [3:0]                    found_core;
  logic [KEY_WIDTH-1:0]          found_key;

  logic                 wr_en, wr_ok, ctrl_wr, start_req, start_ok, start_bad, abort_req;
  logic                 irq_clr, found_set, busy, rd_err;
  logic [AW-1:0]        wr_off, ar_off;
  logic [31:0]          rd_data;
  logic                 arb_any;
  logic [3:0]           arb_idx;
  logic [KEY_WIDTH-1:0] arb_key;
  logic                 unused_bits;

  des_found_arbiter #(.N_CORES(N_CORES), .KEY_WIDTH(KEY_WIDTH)) u_arb (
    .found(i_core_found), .keys(i_core_key), .any(arb_any), .idx(arb_idx), .key(arb_key)
  );

  assign busy         = |i_core_busy;
  assign wr_en        = aw_full & w_full & ~s_axi.bvalid;
  assign wr_off       = {aw_word, 2'b00};
  assign ar_off       = {s_axi.araddr[AW-1:2], 2'b00};
  assign ctrl_wr      = wr_en & (wr_off == ADDR_CTRL) & w_strb[0];
  assign abort_req    = ctrl_wr & w_data[CTRL_ABORT];
  assign start_req    = ctrl_wr & w_data[CTRL_START] & ~w_data[CTRL_ABORT];
  assign start_ok     = start_req & ~busy;
  assign start_bad    = start_req & busy;
  assign irq_clr      = wr_en & (wr_off == ADDR_IRQ_STAT) & w_strb[0] & w_data[0];
  // A found strobe landing together with an accepted START is dropped: the new search owns the result.
  assign found_set    = arb_any & ~found & ~start_ok;
  assign o_irq        = irq_found & irq_en;
  assign o_plaintext  = {dregs[1], dregs[0]};
  assign o_ciphertext = {dregs[3], dregs[2]};
  assign o_key_start  = {dregs[5][KEY_WIDTH-33:0], dregs[4]};
  assign o_key_end    = {dregs[7][KEY_WIDTH-33:0], dregs[6]};
  assign unused_bits  = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Decode whether the committed write targets a writable register.
  always_comb begin
    wr_ok = 1'b0;
    case (wr_off)
      ADDR_CTRL, ADDR_PT_LO, ADDR_PT_HI, ADDR_CT_LO, ADDR_CT_HI,
      ADDR_KS_LO, ADDR_KS_HI, ADDR_KE_LO, ADDR_KE_HI, ADDR_IRQ_STAT: wr_ok = 1'b1;
      default: wr_ok = 1'b0;
    endcase
  end

  // Read-data mux; unmapped offsets return zero with an error flag.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (ar_off)
      ADDR_CTRL:     rd_data[CTRL_IRQ_EN] = irq_en;
      ADDR_STATUS: begin
        rd_data[STAT_BUSY]            = busy;
        rd_data[STAT_FOUND]           = found;
        rd_data[STAT_REJ]             = start_rej;
        rd_data[STAT_CORE_LSB +: 4]   = found_core;
      end
      ADDR_FKEY_LO:  rd_data = found_key[31:0];
      ADDR_FKEY_HI:  rd_data = 32'(found_key[KEY_WIDTH-1:32]);
      ADDR_IRQ_STAT: rd_data[0] = irq_found;
      ADDR_PT_LO, ADDR_PT_HI, ADDR_CT_LO, ADDR_CT_HI,
      ADDR_KS_LO, ADDR_KS_HI, ADDR_KE_LO, ADDR_KE_HI: begin
        for (int i = 0; i < 8; i++) if (s_axi.araddr[AW-1:2] == (AW-2)'(i + 2)) rd_data = dregs[i];
      end
      default:       rd_err = 1'b1;
    endcase
  end

  // Write channel: independent AW/W slots, commit when both are full, single outstanding response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_word       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      s_axi.awready <= ~s_axi.awready & s_axi.awvalid & ~aw_full & ~s_axi.bvalid;
      s_axi.wready  <= ~s_axi.wready & s_axi.wvalid & ~w_full & ~s_axi.bvalid;
      if (s_axi.awready && s_axi.awvalid) begin
        aw_full <= 1'b1;
        aw_word <= s_axi.awaddr[AW-1:2];
      end
      if (s_axi.wready && s_axi.wvalid) begin
        w_full <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (wr_en) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi.bvalid && s_axi.bready) begin
        s_axi.bvalid <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle ARREADY pulse, registered data, hold until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
    end else begin
      s_axi.arready <= ~s_axi.arready & s_axi.arvalid & ~s_axi.rvalid;
      if (s_axi.arready && s_axi.arvalid) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata  <= rd_data;
        s_axi.rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi.rvalid && s_axi.rready) begin
        s_axi.rvalid <= 1'b0;
      end
    end
  end

  // Byte-masked storage for the plaintext/ciphertext/key-range registers and irq enable.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dregs  <= '0;
      irq_en <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < 8; i++)
        if (aw_word == (AW-2)'(i + 2)) dregs[i] <= apply_strb(dregs[i], w_data, w_strb);
      if (wr_off == ADDR_CTRL && w_strb[1]) irq_en <= w_data[CTRL_IRQ_EN];
    end
  end

  // Search control: start/abort pulses, first-found capture, sticky interrupt status.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      o_start    <= 1'b0;
      o_abort    <= 1'b0;
      found      <= 1'b0;
      found_core <= '0;
      found_key  <= '0;
      start_rej  <= 1'b0;
      irq_found  <= 1'b0;
    end else begin
      o_start <= start_ok;
      o_abort <= abort_req;
      if (start_bad) start_rej <= 1'b1;
      if (start_ok) begin
        found      <= 1'b0;
        found_core <= '0;
        found_key  <= '0;
        start_rej  <= 1'b0;
      end else if (found_set) begin
        found      <= 1'b1;
        found_core <= arb_idx;
        found_key  <= arb_key;
      end
      if (found_set)    irq_found <= 1'b1;
      else if (irq_clr) irq_found <= 1'b0;
    end
  end
endmodule

// File: tb/tb_des_crack_axil_ctrl.sv
// Directed bench for the DES cracker AXI4-Lite control slave.
module tb_des_crack_axil_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  pt, ct;
  logic [55:0]  ks, ke;
  logic         o_start, o_abort, o_irq;
  logic [3:0]   core_busy, core_found;
  logic [223:0] core_key;
  int           n_chk = 0, n_pass = 0;
  logic [31:0]  rd;
  logic [1:0]   resp, st, ab;
  logic         ok;

  localparam logic [55:0] K0 = 56'h00_1111_1111_1111;
  localparam logic [55:0] K1 = 56'hAB_CDEF_0123_4567;
  localparam logic [55:0] K2 = 56'h55_AAAA_5555_AAAA;
  localparam logic [55:0] K3 = 56'h99_8877_6655_4433;

  des_crack_axil_ctrl_if #(.ADDR_W(6), .DATA_W(32)) axi ();

  des_crack_axil_ctrl #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .N_CORES(4), .KEY_WIDTH(56)) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(axi.slave),
    .o_plaintext(pt), .o_ciphertext(ct), .o_key_start(ks), .o_key_end(ke),
    .o_start(o_start), .o_abort(o_abort),
    .i_core_busy(core_busy), .i_core_found(core_found), .i_core_key(core_key), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // AW presented at once, W after w_delay cycles; fmask pulses i_core_found in the commit cycle.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_delay, input logic [3:0] fmask,
                           output logic [1:0] bresp, output logic okv,
                           output logic [1:0] stp, output logic [1:0] abp);
    logic aw_done, w_done, aw_go, w_go, b1, b2, b3;
    aw_done = 1'b0; w_done = 1'b0;
    @(negedge clk);
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb;
    for (int c = 0; c < 32 && !(aw_done && w_done); c++) begin
      if (c == w_delay) axi.wvalid = 1'b1;
      aw_go = axi.awvalid && axi.awready;
      w_go  = axi.wvalid && axi.wready;
      @(negedge clk);
      if (aw_go) begin axi.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin axi.wvalid = 1'b0;  w_done = 1'b1; end
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    core_found = fmask;
    @(negedge clk);
    core_found = '0;
    b1 = axi.bvalid; bresp = axi.bresp; stp[1] = o_start; abp[1] = o_abort;
    @(negedge clk);
    b2 = axi.bvalid; stp[0] = o_start; abp[0] = o_abort;
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    b3 = axi.bvalid;
    okv = aw_done & w_done & b1 & b2 & ~b3;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                          output logic [1:0] rresp, output logic okv);
    logic done, go, v1;
    done = 1'b0;
    @(negedge clk);
    axi.araddr = addr; axi.arvalid = 1'b1;
    for (int c = 0; c < 32 && !done; c++) begin
      go = axi.arvalid && axi.arready;
      @(negedge clk);
      if (go) begin axi.arvalid = 1'b0; done = 1'b1; end
    end
    axi.arvalid = 1'b0;
    v1 = axi.rvalid; data = axi.rdata; rresp = axi.rresp;
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    okv = done & v1 & ~axi.rvalid;
  endtask

  initial begin
    rst_n = 1'b0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    core_busy = '0; core_found = '0; core_key = {K3, K2, K1, K0};
    repeat (3) @(negedge clk);
    chk("rst_ready", {61'd0, axi.awready, axi.wready, axi.arready}, 64'd0);
    chk("rst_valid_resp", {58'd0, axi.bvalid, axi.rvalid, axi.bresp, axi.rresp}, 64'd0);
    chk("rst_pulses", {61'd0, o_start, o_abort, o_irq}, 64'd0);
    chk("rst_pt", pt, 64'd0);
    rst_n = 1'b1;

    // Strobed write then read-back
    axi_write(6'h08, 32'h0123_4567, 4'b0101, 0, 4'h0, resp, ok, st, ab);
    chk("ptlo_wr_ok", {63'd0, ok}, 64'd1);
    chk("ptlo_bresp", {62'd0, resp}, 64'd0);
    axi_read(6'h08, rd, resp, ok);
    chk("ptlo_rd", {31'd0, ok, resp, rd}, {31'd0, 1'b1, 2'b00, 32'h0023_0067});

    // AW leads W by three cycles
    axi_write(6'h0C, 32'hDEAD_BEEF, 4'hF, 3, 4'h0, resp, ok, st, ab);
    chk("aw_lead_b", {61'd0, ok, resp}, {61'd0, 1'b1, 2'b00});
    chk("pt_out", pt, 64'hDEAD_BEEF_0023_0067);

    // Unmapped read, RO write
    axi_read(6'h38, rd, resp, ok);
    chk("unmapped_rd", {31'd0, ok, resp, rd}, {31'd0, 1'b1, 2'b10, 32'd0});
    axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, 0, 4'h0, resp, ok, st, ab);
    chk("ro_bresp", {61'd0, ok, resp}, {61'd0, 1'b1, 2'b10});
    axi_read(6'h04, rd, resp, ok);
    chk("status_idle", {31'd0, ok, resp, rd}, {31'd0, 1'b1, 2'b00, 32'd0});

    // Accepted start with irq_en
    axi_write(6'h00, 32'h0000_0101, 4'hF, 0, 4'h0, resp, ok, st, ab);
    chk("start_pulse", {60'd0, st, ab}, {60'd0, 2'b10, 2'b00});
    axi_read(6'h00, rd, resp, ok);
    chk("ctrl_rd", {31'd0, ok, resp, rd}, {31'd0, 1'b1, 2'b00, 32'h0000_0100});

    // Cores 1 and 3 find together: core 1 wins
    @(negedge clk); core_found = 4'b1010;
    @(negedge clk); core_found = 4'b0000;
    chk("irq_on", {63'd0, o_irq}, 64'd1);
    axi_read(6'h28, rd, resp, ok);
    chk("fkey_lo", {31'd0, ok, resp, rd}, {31'd0, 1'b1, 2'b00, 32'h0123_4567});
    axi_read(6'h2C, rd, resp, ok);
    chk("fkey_hi", {31'd0, ok, resp, rd}, {31'd0, 1'b1, 2'b00, 32'h00AB_CDEF});
    axi_read(6'h04, rd, resp, ok);
    chk("status_found", {31'd0, ok, rd}, {31'd0, 1'b1, 32'h0000_0102});
    @(negedge clk); core_found = 4'b0001;
    @(negedge clk); core_found = 4'b0000;
    axi_read(6'h28, rd, resp, ok);
    chk("later_found_ignored", {32'd0, rd}, {32'd0, 32'h0123_4567});

    // Start while busy is rejected; start+abort gives abort only
    core_busy = 4'b0001;
    axi_write(6'h00, 32'h0000_0001, 4'b0001, 0, 4'h0, resp, ok, st, ab);
    chk("busy_no_start", {60'd0, st, ab}, {60'd0, 2'b00, 2'b00});
    axi_read(6'h04, rd, resp, ok);
    chk("status_rej", {32'd0, rd}, {32'd0, 32'h0000_0107});
    axi_write(6'h00, 32'h0000_0003, 4'b0001, 0, 4'h0, resp, ok, st, ab);
    chk("abort_wins", {60'd0, st, ab}, {60'd0, 2'b00, 2'b10});
    chk("irq_kept", {63'd0, o_irq}, 64'd1);

    // W1C, fresh start, then W1C racing a found strobe
    axi_write(6'h30, 32'h0000_0001, 4'hF, 0, 4'h0, resp, ok, st, ab);
    chk("irq_w1c", {61'd0, o_irq, resp}, 64'd0);
    core_busy = 4'b0000;
    axi_write(6'h00, 32'h0000_0001, 4'b0001, 0, 4'h0, resp, ok, st, ab);
    chk("restart_pulse", {60'd0, st, ab}, {60'd0, 2'b10, 2'b00});
    axi_read(6'h04, rd, resp, ok);
    chk("status_cleared", {32'd0, rd}, 64'd0);
    axi_write(6'h30, 32'h0000_0001, 4'hF, 0, 4'b1000, resp, ok, st, ab);
    chk("set_wins_irq", {63'd0, o_irq}, 64'd1);
    axi_read(6'h30, rd, resp, ok);
    chk("set_wins_stat", {32'd0, rd}, 64'd1);
    axi_read(6'h04, rd, resp, ok);
    chk("status_core3", {32'd0, rd}, {32'd0, 32'h0000_0302});
    axi_read(6'h28, rd, resp, ok);
    chk("fkey3_lo", {32'd0, rd}, {32'd0, 32'h6655_4433});

    // Reset in the middle of a read
    @(negedge clk); axi.araddr = 6'h08; axi.arvalid = 1'b1;
    @(negedge clk);
    @(negedge clk); axi.arvalid = 1'b0;
    chk("midread_rvalid", {63'd0, axi.rvalid}, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("midread_reset", {63'd0, axi.rvalid}, 64'd0);
    chk("reset_pt", pt, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {62'd0, axi.arready, axi.rvalid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
